// File: rtl/sync_ram_pkg.sv
// Shared sizing helpers, reset polarity and response-buffer state type for sync_ram.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package sync_ram_pkg;

  // Reset is asserted when rst carries this level.
  localparam logic RST_ACTIVE = 1'b0;

  // One-entry response buffer occupancy.
  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  // Number of byte lanes in a data word.
  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  // Index width for the storage array; a single-word RAM still needs one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_ram_array.sv
// Word storage with per-byte write enables and a registered read port.
// Latency: write commits at the enabled edge; read data appears one edge after the enabled read.
// Backpressure: none; rdata holds its value on every cycle en is low.
module sync_ram_array
  import sync_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 100
) (
  input  logic                              clk,
  input  logic                              en,
  input  logic                              we,
  input  logic [strb_width(DATA_WIDTH)-1:0] wstrb,
  input  logic [idx_width(DEPTH)-1:0]       idx,
  input  logic [DATA_WIDTH-1:0]             wdata,
  output logic [DATA_WIDTH-1:0]             rdata
);

  localparam int STRB_W = strb_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-masked write, or registered read; rdata only moves on an enabled read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wstrb[b]) begin
            mem[idx][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/sync_ram.sv
// Windowed data RAM on the CPU bus with valid/ready request and response channels.
// Latency: one cycle from request accept to rsp_valid; one request per cycle at full rate.
// Backpressure: a held response (rsp_valid && !rsp_ready) drops req_ready until it pops.
module sync_ram
  import sync_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 100,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_we,
  input  logic [ADDR_WIDTH-1:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]             req_wdata,
  input  logic [strb_width(DATA_WIDTH)-1:0] req_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              rsp_err
);

  localparam int                    IDX_W   = idx_width(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  buf_state_t            state_q;
  buf_state_t            state_d;
  logic                  in_reset;
  logic                  accept;
  logic                  pop;
  logic                  in_win;
  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      idx;
  logic                  rsp_err_q;
  logic                  rsp_rd_q;
  logic [DATA_WIDTH-1:0] arr_rdata;

  // Window test done as subtract-then-compare so BASE_ADDR + DEPTH never has to fit in ADDR_WIDTH.
  assign offset = req_addr - BASE_ADDR;
  assign in_win = (req_addr >= BASE_ADDR) && (offset < DEPTH_A);
  assign idx    = offset[IDX_W-1:0];

  assign in_reset  = (rst == RST_ACTIVE);
  assign rsp_valid = (state_q == BUF_FULL);
  assign req_ready = !in_reset && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  // Only in-window accepts touch the array, so out-of-window writes leave storage intact.
  sync_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (accept && in_win),
    .we    (req_we),
    .wstrb (req_wstrb),
    .idx   (idx),
    .wdata (req_wdata),
    .rdata (arr_rdata)
  );

  // Response buffer occupancy register.
  always_ff @(posedge clk) begin
    if (in_reset) begin
      state_q <= BUF_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Buffer next state: fill on accept, drain on a pop with no simultaneous accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BUF_EMPTY: if (accept) state_d = BUF_FULL;
      BUF_FULL:  if (pop && !accept) state_d = BUF_EMPTY;
      default:   state_d = BUF_EMPTY;
    endcase
  end

  // Capture the response kind at accept; held unchanged while the response stalls.
  always_ff @(posedge clk) begin
    if (in_reset) begin
      rsp_err_q <= 1'b0;
      rsp_rd_q  <= 1'b0;
    end else if (accept) begin
      rsp_err_q <= !in_win;
      rsp_rd_q  <= in_win && !req_we;
    end
  end

  // Read data is only forwarded for in-window reads; writes, errors and an empty buffer give 0.
  assign rsp_rdata = (rsp_valid && rsp_rd_q) ? arr_rdata : '0;
  assign rsp_err   = rsp_valid && rsp_err_q;

endmodule

// File: doc/sync_ram.md
# sync_ram

Parametrised, synchronous, word-addressed data RAM for the CPU data bus. Successor to the single-cycle combinational RAM: storage is clocked, read data is registered, writes support byte strobes, and every access completes through a valid/ready request and response handshake. Addresses outside the RAM window get an error response instead of a floating bus. It sits on the CPU data bus beside the GPIO and other peripherals.

## Interface
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8.
- `DEPTH`, 100: number of words.
- `ADDR_WIDTH`, 32: bus address width.
- `BASE_ADDR`, 0: first word address of the RAM window.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: request accepted when `req_valid && req_ready`.
- `req_we` input 1: 1 = write, 0 = read.
- `req_addr` input ADDR_WIDTH: word address.
- `req_wdata` input DATA_WIDTH: write data.
- `req_wstrb` input DATA_WIDTH/8: byte enables; bit i covers bits [8i+7:8i].
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_rdata` output DATA_WIDTH: read data. It is 0 for writes and for errors.
- `rsp_err` output 1: access was outside the RAM window.

## Operation
- **Window.** The RAM window is `BASE_ADDR <= req_addr < BASE_ADDR + DEPTH`, compared at full ADDR_WIDTH with no truncation. Index = `req_addr - BASE_ADDR`, `$clog2(DEPTH)` bits.
- **Accepted in-window write.** Each byte with its strobe set is written at the accept edge. Bytes with a clear strobe keep their old value. `wstrb` = 0 is legal: nothing is written, and a normal response is returned.
- **Accepted in-window read.** `rsp_rdata` = stored word at the index.
- **Accepted out-of-window access.** Memory is not modified; `rsp_err`=1 and `rsp_rdata`=0. No output is ever driven to Z.
- **Responses.** Every accepted request produces exactly one response, reads and writes alike, with `rsp_err` set as above.
- **Response buffer.** It holds one entry, giving two states:
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
  - Transition on accept without pop: EMPTY→FULL.
  - Transition on pop without accept: FULL→EMPTY.
  - Accept and pop in the same cycle: stays FULL, loaded with the new response.
- **Ready.** `req_ready = !rsp_valid || rsp_ready`. It is combinational from `rsp_ready` only and never depends on `req_valid`.
- **Stable response.** While `rsp_valid && !rsp_ready`, `rsp_rdata` and `rsp_err` hold stable.
- **Back-to-back reads.** A write followed by a read of the same word returns the newly written data, since the write commits at the earlier edge. With one request per cycle there is no same-cycle read/write collision.
- **Reset (`rst`=0 at a clock edge).**
  - Outputs: `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - Handshake: `req_ready`=0 while in reset, with no request accepted and no memory write.
  - Storage: contents are not reset and hold their value.
  - In-flight work: a pending response is dropped.
  - Release: `req_ready` is 1 in the first cycle after release.

## Timing
- Latency: a request accepted at edge N gives `rsp_valid`=1 after edge N, visible in cycle N+1.
- Throughput: one request per cycle while `rsp_ready` is held at 1.
- Backpressure: `rsp_ready`=0 with a full buffer forces `req_ready`=0. Requests stall and no data is lost.
- Critical path: address compare plus subtract feeding the array enable. The window limits are constants.

## Structure
- Shared package `sync_ram_pkg`:
  - strobe width function `DATA_WIDTH/8`;
  - index width `$clog2(DEPTH)`;
  - reset-polarity constant for active-low reset.
- Sub-module `sync_ram_array`:
  - inferable storage with byte-enabled write and registered read;
  - ports: clk, en, we, wstrb, idx, wdata, rdata.
- Top level `sync_ram` owns:
  - window decode;
  - handshake and response buffer;
  - error/zero muxing of `rsp_rdata`.

## Test plan
- **Reset.** Hold `rst`=0 for 3 cycles with `req_valid`=1 → `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `req_ready`=0. After release, `req_ready`=1.
- **Write then read.** Write `0xDEADBEEF` to addr 5 with wstrb `4'hF`, then read addr 5 → responses in consecutive cycles. Read `rsp_rdata`=`0xDEADBEEF`, `rsp_err`=0.
- **Byte strobes.** Addr 7 holds `0x11223344`. Write `0xAABBCCDD` with wstrb `4'b0101`, then read → `0x11BB33DD`.
- **Window boundary.** Defaults, addr 99 and addr 100:
  - read addr 99 → `rsp_err`=0;
  - write then read addr 100 → `rsp_err`=1 and `rsp_rdata`=0 on both, with word 99 unchanged.
  - Repeat with `BASE_ADDR`=`0x100`: addr `0xFF` errors and addr `0x100` maps to index 0.
- **Backpressure.** Issue back-to-back reads with `rsp_ready`=0 for 4 cycles:
  - one request is accepted, then `req_ready`=0;
  - the response holds stable;
  - when `rsp_ready` rises, the next request is accepted in the same cycle the held response pops.
- **Reset mid-operation.** Assert `rst`=0 while `rsp_valid`=1 → `rsp_valid`=0 next cycle. After release, read the earlier-written word → prior contents returned.
